fix_add_sub_vec: RTL and testbench
==================================

// Module: fix_add_sub_vec
// PURPOSE
//   Multi-lane fixed-point add/sub with a valid/ready stream interface.
//   Per-beat op select, operand swap, rounded right shift and saturation.
//   PIPE-deep stallable pipeline; per-lane saturation flags; sticky saturation counter.
//   Sits between stream producers (FFT/filter datapaths) and consumers that may backpressure.
// PARAMETERS
//   LANES      4   independent channels processed per beat
//   IN_WIDTH   16  signed two's-complement operand width per lane
//   OUT_WIDTH  16  signed result width per lane (saturated)
//   PIPE       2   register stages, input to output (legal 1..4)
//   CNT_WIDTH  16  width of saturation event counter
//   SW         $clog2(IN_WIDTH+2)  derived localparam: shift field width, not overridable
// PORTS
//   clk        in   1                clock
//   rst        in   1                synchronous reset, active-high
//   in_valid   in   1                input beat valid
//   in_ready   out  1                block accepts beat this cycle
//   opa        in   LANES*IN_WIDTH   lane i at [i*IN_WIDTH +: IN_WIDTH]
//   opb        in   LANES*IN_WIDTH   same packing
//   sub        in   1                0: a+b, 1: a-b (sampled with beat)
//   flip       in   1                1: swap a/b before op (sampled with beat)
//   shift_amt  in   SW               rounded arithmetic right shift, 0..IN_WIDTH+1
//   out_valid  out  1                output beat valid
//   out_ready  in   1                consumer accepts beat
//   out        out  LANES*OUT_WIDTH  lane results, same packing
//   out_sat    out  LANES            per-lane saturation flag, aligned with out
//   sat_cnt    out  CNT_WIDTH        beats delivered with any out_sat bit set
//   cnt_clr    in   1                synchronous clear of sat_cnt
// BEHAVIOUR
//   Handshake: beat transfers on valid&ready at either port.
//   out_valid, out, out_sat hold stable while out_valid & ~out_ready.
//   Pipeline: PIPE stages, each with its own valid bit.
//   stage k loads when empty or when stage k+1 (or the consumer) takes its content.
//   in_ready = ~v[0] | advance[0], combinational from out_ready; bubbles collapse.
//   Latency: PIPE cycles from input accept to out_valid when unstalled.
//   Throughput: 1 beat/cycle.
//   Per lane arithmetic:
//     x,y = flip ? (b,a) : (a,b)
//     s   = sub ? x-y : x+y, sign-extended to IN_WIDTH+2
//     shift_amt n > 0: r = (s + 2^(n-1)) >>> n  (round half up)
//     shift_amt 0:     r = s
//     saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
//     out_sat = 1 iff clamping occurred
//   Arithmetic stage split:
//     PIPE=1: all arithmetic feeds the single register.
//     PIPE>=2: stage0 registers s plus n; stage1 rounds/shifts/saturates.
//     remaining stages are pure delay.
//   shift_amt > IN_WIDTH+1: treated as IN_WIDTH+1.
//   sat_cnt: +1 on each output transfer with |out_sat.
//   sat_cnt saturates at all-ones, no wrap.
//   sat_cnt: cnt_clr wins over a simultaneous increment.
//   Reset: all stage valids, out_valid, out, out_sat, sat_cnt = 0.
//   in_ready = 1 the first cycle after rst deasserts.
//   Reset mid-operation: in-flight beats are discarded, no output.
//   Datapath registers need no reset; only valids, out and out_sat reset.
// STRUCTURE
//   Shared package fix_pkg:
//     function fix_sat_f(value, widths) -> {clamped, flag}
//     function fix_rnd_shift_f
//     typedef for op control {sub, flip, shift}
//   Sub-module fix_lane_addsub: one lane; arithmetic stage, shift/sat stage.
//   Top: generates LANES of fix_lane_addsub, a shared valid/ready stage
//   controller, and the sat_cnt counter.
// TESTING (LANES=4, IN=OUT=16, PIPE=2)
//   0x7FFF+0x0001, n=0 -> out 0x7FFF, out_sat=1, sat_cnt 1 after transfer.
//   0x8000-0x0001 -> 0x8000 sat.
//   flip=1, sub=1, a=0x0005, b=0x0003 -> 0xFFFE, sat=0.
//   0x0003+0x0000, n=1 -> 0x0002.
//   0xFFFD+0, n=1 -> 0xFFFF.
//   0x7FFF+0x7FFF, n=1 -> 0x7FFF, sat=0 (no overflow thanks to the extra bit).
//   Stream 8 beats with out_ready low cycles 3-6:
//     in_ready low after pipe fills; no loss/dup; order kept.
//     out held stable while stalled; full rate once out_ready=1.
//   Assert rst with 2 beats in flight:
//     next cycle out_valid=0, sat_cnt=0; no stale beat after release.
//   Drive sat_cnt to 0xFFFF, more sat beats -> stays 0xFFFF.
//   cnt_clr with a simultaneous sat beat -> 0.

Source files
------------

// File: rtl/fix_pkg.sv
// fix_pkg: shared types and helpers for the fixed-point add/sub lanes.
// Helpers work on a wide signed carrier so any lane width fits.
package fix_pkg;

   localparam int FW = 64;
   localparam int SHIFT_W = 8;

   typedef struct packed {
      logic sub;
      logic flip;
      logic [SHIFT_W-1:0] shift;
   } op_ctl_t;

   typedef struct packed {
      logic signed [FW-1:0] val;
      logic flag;
   } sat_t;

   function automatic logic signed [FW-1:0] fix_rnd_shift_f(
      input logic signed [FW-1:0] v,
      input logic [SHIFT_W-1:0] n
   );
      logic signed [FW-1:0] half;
      logic signed [FW-1:0] r;
      half = 64'sd1;
      r = v;
      if (n != '0) begin
         half = half <<< (n - 1'b1);
         r = (v + half) >>> n;
      end
      return r;
   endfunction

   function automatic sat_t fix_sat_f(
      input logic signed [FW-1:0] v,
      input int ow
   );
      logic signed [FW-1:0] hi;
      logic signed [FW-1:0] lo;
      sat_t r;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      r.flag = (v > hi) || (v < lo);
      r.val = (v > hi) ? hi : ((v < lo) ? lo : v);
      return r;
   endfunction

endpackage

// File: rtl/fix_lane_addsub.sv
// fix_lane_addsub: one lane of the vector add/sub.
// Exact sum/difference, then round-shift and saturate, then delay.
module fix_lane_addsub
   import fix_pkg::*;
#(
   parameter int IN_WIDTH = 16,
   parameter int OUT_WIDTH = 16,
   parameter int PIPE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic [PIPE-1:0] en,
   input  logic [IN_WIDTH-1:0] a,
   input  logic [IN_WIDTH-1:0] b,
   input  op_ctl_t ctl,
   output logic [OUT_WIDTH-1:0] res,
   output logic sat
);

   localparam int SUM_W = IN_WIDTH + 2;
   localparam int FIRST = (PIPE == 1) ? 0 : 1;
   localparam int DEPTH = PIPE - FIRST;
   localparam logic [SHIFT_W-1:0] N_MAX = SHIFT_W'(IN_WIDTH + 1);

   logic signed [SUM_W-1:0] x, y, s, cs;
   logic [SHIFT_W-1:0] n, cn;
   logic signed [FW-1:0] wide, rnd;
   sat_t st;
   logic [FW-OUT_WIDTH-1:0] unused_hi;
   logic [OUT_WIDTH-1:0] pr_res;
   logic pr_sat;
   logic [DEPTH-1:0][OUT_WIDTH-1:0] rq, d_res;
   logic [DEPTH-1:0] sq, d_sat;

   // operand swap, full-precision add/sub, shift clamp
   always_comb begin
      x = ctl.flip ? {{2{b[IN_WIDTH-1]}}, b} : {{2{a[IN_WIDTH-1]}}, a};
      y = ctl.flip ? {{2{a[IN_WIDTH-1]}}, a} : {{2{b[IN_WIDTH-1]}}, b};
      s = ctl.sub ? x - y : x + y;
      n = (ctl.shift > N_MAX) ? N_MAX : ctl.shift;
   end

   if (PIPE == 1) begin : g_comb
      // single stage: arithmetic feeds the output register directly
      always_comb begin
         cs = s;
         cn = n;
      end
   end else begin : g_reg
      logic signed [SUM_W-1:0] s_q;
      logic [SHIFT_W-1:0] n_q;
      // stage 0 holds the exact sum and the clamped shift
      always_ff @(posedge clk) begin
         if (en[0]) begin
            s_q <= s;
            n_q <= n;
         end
      end
      // stage 1 works from the registered sum
      always_comb begin
         cs = s_q;
         cn = n_q;
      end
   end

   // round half up, arithmetic shift, clamp to the output range
   always_comb begin
      wide = {{(FW-SUM_W){cs[SUM_W-1]}}, cs};
      rnd = fix_rnd_shift_f(wide, cn);
      st = fix_sat_f(rnd, OUT_WIDTH);
      pr_res = st.val[OUT_WIDTH-1:0];
      unused_hi = st.val[FW-1:OUT_WIDTH];
      pr_sat = st.flag;
   end

   // next value for each result stage
   always_comb begin
      d_res = rq;
      d_sat = sq;
      d_res[0] = pr_res;
      d_sat[0] = pr_sat;
      for (int k = 1; k < DEPTH; k++) begin
         d_res[k] = rq[k-1];
         d_sat[k] = sq[k-1];
      end
   end

   // result stages; only the visible last one is reset
   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         if (en[FIRST+k]) begin
            rq[k] <= d_res[k];
            sq[k] <= d_sat[k];
         end
      end
      if (rst) begin
         rq[DEPTH-1] <= '0;
         sq[DEPTH-1] <= 1'b0;
      end
   end

   assign res = rq[DEPTH-1];
   assign sat = sq[DEPTH-1];

endmodule

// File: rtl/fix_add_sub_vec.sv
// fix_add_sub_vec: multi-lane fixed-point add/sub stream block.
// Stallable valid/ready pipeline with a sticky saturation counter.
module fix_add_sub_vec
   import fix_pkg::*;
#(
   parameter int LANES = 4,
   parameter int IN_WIDTH = 16,
   parameter int OUT_WIDTH = 16,
   parameter int PIPE = 2,
   parameter int CNT_WIDTH = 16,
   localparam int SW = $clog2(IN_WIDTH + 2)
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic [LANES*IN_WIDTH-1:0] opa,
   input  logic [LANES*IN_WIDTH-1:0] opb,
   input  logic sub,
   input  logic flip,
   input  logic [SW-1:0] shift_amt,
   output logic out_valid,
   input  logic out_ready,
   output logic [LANES*OUT_WIDTH-1:0] out,
   output logic [LANES-1:0] out_sat,
   output logic [CNT_WIDTH-1:0] sat_cnt,
   input  logic cnt_clr
);

   logic [PIPE-1:0] v, load, vin, en;
   op_ctl_t ctl;

   // a stage loads when empty or when its content moves downstream
   always_comb begin
      logic nxt;
      nxt = out_ready;
      load = '0;
      vin = '0;
      for (int k = PIPE - 1; k >= 0; k--) begin
         load[k] = ~v[k] | nxt;
         nxt = load[k];
      end
      vin[0] = in_valid;
      for (int k = 1; k < PIPE; k++) begin
         vin[k] = v[k-1];
      end
      en = load & vin;
   end

   // per-stage valid bits; bubbles collapse on load
   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
      end else begin
         v <= (load & vin) | (~load & v);
      end
   end

   assign in_ready = load[0];
   assign out_valid = v[PIPE-1];

   // per-beat op control shared by all lanes
   always_comb begin
      ctl = '0;
      ctl.sub = sub;
      ctl.flip = flip;
      ctl.shift[SW-1:0] = shift_amt;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fix_lane_addsub #(
         .IN_WIDTH(IN_WIDTH),
         .OUT_WIDTH(OUT_WIDTH),
         .PIPE(PIPE)
      ) u_lane (
         .clk(clk),
         .rst(rst),
         .en(en),
         .a(opa[i*IN_WIDTH +: IN_WIDTH]),
         .b(opb[i*IN_WIDTH +: IN_WIDTH]),
         .ctl(ctl),
         .res(out[i*OUT_WIDTH +: OUT_WIDTH]),
         .sat(out_sat[i])
      );
   end

   // count delivered beats with any clamped lane; clear wins
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         sat_cnt <= '0;
      end else if (out_valid && out_ready && (|out_sat) && !(&sat_cnt)) begin
         sat_cnt <= sat_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fix_add_sub_vec.sv
// tb_fix_add_sub_vec: scoreboard bench for fix_add_sub_vec.
// Directed beats; a monitor pops expected results on each output transfer.
module tb_fix_add_sub_vec;

   localparam int LANES = 4;
   localparam int IW = 16;
   localparam int OW = 16;
   localparam int PIPE = 2;
   localparam int CW = 16;
   localparam int SW = $clog2(IW + 2);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [LANES*IW-1:0] opa = '0;
   logic [LANES*IW-1:0] opb = '0;
   logic sub = 1'b0;
   logic flip = 1'b0;
   logic [SW-1:0] shift_amt = '0;
   logic out_valid;
   logic out_ready = 1'b1;
   logic [LANES*OW-1:0] out;
   logic [LANES-1:0] out_sat;
   logic [CW-1:0] sat_cnt;
   logic cnt_clr = 1'b0;

   always #5 clk = ~clk;

   fix_add_sub_vec #(
      .LANES(LANES),
      .IN_WIDTH(IW),
      .OUT_WIDTH(OW),
      .PIPE(PIPE),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .opa(opa),
      .opb(opb),
      .sub(sub),
      .flip(flip),
      .shift_amt(shift_amt),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out(out),
      .out_sat(out_sat),
      .sat_cnt(sat_cnt),
      .cnt_clr(cnt_clr)
   );

   typedef struct packed {
      logic [LANES*OW-1:0] res;
      logic [LANES-1:0] sat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int n_cmp = 0;
   int n_bad = 0;
   int ir_low = 0;
   logic [CW-1:0] exp_cnt = '0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // monitor: compare on transfer, check hold while stalled
   always @(negedge clk) begin
      logic xs;
      xs = 1'b0;
      if (rst) begin
         sb.delete();
         exp_cnt = '0;
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_beat: got %h, none pending", out);
            end else if (out_ready) begin
               mon_e = sb.pop_front();
               check("beat_out", out, mon_e.res);
               check("beat_sat", 64'(out_sat), 64'(mon_e.sat));
               xs = |mon_e.sat;
            end else begin
               check("stall_hold", out, sb[0].res);
            end
         end
         if (cnt_clr) exp_cnt = '0;
         else if (xs && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      end
   end

   task automatic send(input logic [LANES*IW-1:0] a,
                       input logic [LANES*IW-1:0] b,
                       input logic s, input logic f,
                       input logic [SW-1:0] n,
                       input logic [LANES*OW-1:0] er,
                       input logic [LANES-1:0] es);
      int guard;
      logic acc;
      exp_t e;
      guard = 0;
      opa = a;
      opb = b;
      sub = s;
      flip = f;
      shift_amt = n;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready;
         if (!acc) ir_low++;
         if (acc) begin
            e.res = er;
            e.sat = es;
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
         guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got in_ready 0 want 1");
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int g;
      g = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while (sb.size() != 0 && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] B1A = {16'h1234, 16'h8000, 16'h0001, 16'h7FFF};
   localparam logic [63:0] B1B = {16'h1111, 16'hFFFF, 16'h0002, 16'h0001};
   localparam logic [63:0] B1R = {16'h2345, 16'h8000, 16'h0003, 16'h7FFF};

   initial begin
      logic [LANES*IW-1:0] sa;
      logic [LANES*IW-1:0] sbv;
      logic [LANES*OW-1:0] sr;
      int g;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out", out, 64'd0);
      check("rst_out_sat", 64'(out_sat), 64'd0);
      check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // directed beats, back to back at full rate
      send(B1A, B1B, 1'b0, 1'b0, 5'd0, B1R, 4'b0101);
      send({16'h0000, 16'h7FFF, 16'h0005, 16'h8000},
           {16'h0001, 16'hFFFF, 16'h0003, 16'h0001}, 1'b1, 1'b0, 5'd0,
           {16'hFFFF, 16'h7FFF, 16'h0002, 16'h8000}, 4'b0101);
      send({16'h0010, 16'hFFFF, 16'h0003, 16'h0005},
           {16'h0001, 16'h7FFF, 16'h0005, 16'h0003}, 1'b1, 1'b1, 5'd0,
           {16'hFFF1, 16'h7FFF, 16'h0002, 16'hFFFE}, 4'b0100);
      send({16'h8000, 16'h7FFF, 16'hFFFD, 16'h0003},
           {16'h8000, 16'h7FFF, 16'h0000, 16'h0000}, 1'b0, 1'b0, 5'd1,
           {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0002}, 4'b0000);
      send({16'hFFF9, 16'hFFFA, 16'h0005, 16'h0006}, 64'd0,
           1'b0, 1'b0, 5'd2,
           {16'hFFFE, 16'hFFFF, 16'h0001, 16'h0002}, 4'b0000);
      send({16'hC000, 16'h0001, 16'h8000, 16'h7FFF},
           {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}, 1'b0, 1'b0, 5'd16,
           {16'h0000, 16'h0000, 16'hFFFF, 16'h0001}, 4'b0000);
      send({16'h8000, 16'h0001, 16'h8000, 16'h7FFF},
           {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}, 1'b0, 1'b0, 5'd31,
           64'd0, 4'b0000);
      send({16'h0000, 16'h0001, 16'h7FFF, 16'h8000},
           {16'h8000, 16'h0000, 16'h8000, 16'h7FFF}, 1'b1, 1'b1, 5'd0,
           {16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF}, 4'b0011);
      check("full_rate", 64'(ir_low), 64'd0);
      drain();
      check("sat_cnt_4", 64'(sat_cnt), 64'd4);
      check("sat_cnt_model", 64'(sat_cnt), 64'(exp_cnt));

      // 8-beat stream with consumer stalled for 4 cycles
      ir_low = 0;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               for (int i = 0; i < LANES; i++) begin
                  sa[i*IW +: IW] = 16'(256 * k + i);
                  sbv[i*IW +: IW] = 16'h0001;
                  sr[i*OW +: OW] = 16'(256 * k + i + 1);
               end
               send(sa, sbv, 1'b0, 1'b0, 5'd0, sr, 4'b0000);
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      check("in_ready_low_seen", 64'(ir_low != 0), 64'd1);
      drain();

      // reset with two beats in flight
      out_ready = 1'b0;
      send(B1A, B1B, 1'b0, 1'b0, 5'd0, B1R, 4'b0101);
      send(B1A, B1B, 1'b0, 1'b0, 5'd0, B1R, 4'b0101);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      repeat (6) @(posedge clk);
      #1;

      // drive counter into saturation
      for (int k = 0; k < 65538; k++) begin
         send(B1A, B1B, 1'b0, 1'b0, 5'd0, B1R, 4'b0101);
      end
      drain();
      check("sat_cnt_max", 64'(sat_cnt), 64'h0000_0000_0000_FFFF);
      check("sat_cnt_max_model", 64'(sat_cnt), 64'(exp_cnt));

      // clear coinciding with a saturated transfer
      out_ready = 1'b0;
      send(B1A, B1B, 1'b0, 1'b0, 5'd0, B1R, 4'b0101);
      in_valid = 1'b0;
      g = 0;
      while (!out_valid && g < 10) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("clr_beat_ready", 64'(out_valid), 64'd1);
      cnt_clr = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      check("clr_wins", 64'(sat_cnt), 64'd0);
      send(B1A, B1B, 1'b0, 1'b0, 5'd0, B1R, 4'b0101);
      idle();
      drain();
      check("cnt_after_clr", 64'(sat_cnt), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
